// File: rtl/layer_seq_ctrl.sv
// Sequencer for one fully-connected layer: loads an N-word input vector, then
// walks the M x N weight matrix row by row into a single MAC and hands each row result downstream.
module layer_seq_ctrl #(
  parameter int M      = 5,
  parameter int N      = 2,
  parameter int W_ADDW = $clog2(M*N),
  parameter int B_ADDW = (M > 1) ? $clog2(M) : 1,
  parameter int X_ADDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              x_wr_en,
  output logic [X_ADDW-1:0] x_addr,
  output logic [W_ADDW-1:0] w_addr,
  output logic [B_ADDW-1:0] b_addr,
  output logic              mac_valid_in,
  input  logic              mac_valid_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [X_ADDW-1:0] X_LAST = X_ADDW'(N - 1);
  localparam logic [B_ADDW-1:0] B_LAST = B_ADDW'(M - 1);

  state_t            state;
  logic [X_ADDW-1:0] wr_ptr;
  logic [X_ADDW-1:0] col;
  logic [B_ADDW-1:0] row;
  logic [X_ADDW-1:0] x_hold;
  logic [W_ADDW-1:0] w_hold;
  logic [W_ADDW-1:0] w_issue;

  // row < M and col < N keep this at or below M*N-1
  assign w_issue = W_ADDW'(row) * W_ADDW'(N) + W_ADDW'(col);

  assign s_ready = (state == S_LOAD_X);
  assign x_wr_en = s_ready & s_valid;
  assign b_addr  = row;
  assign m_last  = m_valid & (row == B_LAST);

  // WAIT/OUT replay the last issued addresses so the memories stay quiet
  always_comb begin
    x_addr = x_hold;
    w_addr = w_hold;
    if (state == S_LOAD_X) begin
      x_addr = wr_ptr;
    end else if (state == S_ISSUE) begin
      x_addr = col;
      w_addr = w_issue;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      col          <= '0;
      row          <= '0;
      x_hold       <= '0;
      w_hold       <= '0;
      mac_valid_in <= 1'b0;
      m_valid      <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      // one-cycle lag matches the read latency of the RAM and ROMs
      mac_valid_in <= (state == S_ISSUE);
      if (mac_valid_out && (state != S_WAIT)) begin
        proto_err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          state <= S_LOAD_X;
        end
        S_LOAD_X: begin
          if (s_valid) begin
            if (wr_ptr == X_LAST) begin
              wr_ptr <= '0;
              row    <= '0;
              col    <= '0;
              state  <= S_ISSUE;
            end else begin
              wr_ptr <= wr_ptr + X_ADDW'(1);
            end
          end
        end
        S_ISSUE: begin
          x_hold <= col;
          w_hold <= w_issue;
          if (col == X_LAST) begin
            col   <= '0;
            state <= S_WAIT;
          end else begin
            col <= col + X_ADDW'(1);
          end
        end
        S_WAIT: begin
          if (mac_valid_out) begin
            m_valid <= 1'b1;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (row == B_LAST) begin
              row   <= '0;
              state <= S_LOAD_X;
            end else begin
              row   <= row + B_ADDW'(1);
              state <= S_ISSUE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Sequencing controller for one fully-connected layer datapath: input-vector RAM, weight ROM, bias ROM and a single-stage MAC. It accepts an N-element input vector over a valid/ready handshake, issues the M×N weight and input reads row by row into the MAC, and presents each of the M results downstream on a valid/ready handshake. It holds no data. The layer top wires it between the stream ports and the memories/MAC.

## Interface
- M, 5: output rows (bias entries).
- N, 2: input vector length (columns per row).
- W_ADDW, $clog2(M*N): weight ROM address width.
- B_ADDW, max(1,$clog2(M)): bias ROM address width.
- X_ADDW, max(1,$clog2(N)): input RAM address width.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces every register to its reset value immediately.
- s_valid  in  1  upstream input word valid.
- s_ready  out  1  controller accepts an input word.
- x_wr_en  out  1  input RAM write enable.
- x_addr  out  X_ADDW  input RAM address (write in LOAD_X, read in ISSUE).
- w_addr  out  W_ADDW  weight ROM read address.
- b_addr  out  B_ADDW  bias ROM read address.
- mac_valid_in  out  1  MAC operand-valid strobe.
- mac_valid_out  in  1  MAC row result complete.
- m_valid  out  1  MAC result valid to downstream.
- m_ready  in  1  downstream accepts result.
- m_last  out  1  current result is row M-1.
- proto_err  out  1  sticky: mac_valid_out seen outside WAIT.

## Operation
- States: IDLE (reset state), LOAD_X, ISSUE, WAIT, OUT.
- Registers: wr_ptr (X_ADDW), row (B_ADDW), col (X_ADDW), mac_valid_in, m_valid, proto_err, state.
- IDLE: s_ready=0; moves to LOAD_X unconditionally on the next clk.
- LOAD_X:
  - s_ready=1; x_wr_en = s_valid; x_addr = wr_ptr.
  - Each accepted word increments wr_ptr.
  - On an accepted word with wr_ptr==N-1: wr_ptr←0, row←0, col←0, go to ISSUE.
- ISSUE:
  - Outputs: x_addr=col, w_addr=row*N+col, b_addr=row.
  - col increments every cycle.
  - At col==N-1: col←0, go to WAIT.
  - Duration: exactly N cycles per row.
- WAIT:
  - Addresses hold their last ISSUE value; no new strobes.
  - On mac_valid_out: go to OUT.
- OUT:
  - m_valid=1; m_last=(row==M-1).
  - On m_ready: if row==M-1, go to LOAD_X (row←0); else row←row+1 and go to ISSUE.
  - Result data (MAC f) is stable throughout OUT because the MAC receives no strobes.
- mac_valid_in is a registered copy of (state==ISSUE). It aligns with the 1-cycle read latency of the RAM and ROMs.
- s_ready=0 and x_wr_en=0 in every state except LOAD_X. Input words offered outside LOAD_X are neither written nor consumed.
- proto_err sets on mac_valid_out in any state other than WAIT. Only reset clears it. The pulse is otherwise ignored, with no state change.
- w_addr is computed from row*N+col; a constant-width multiply or an incrementing pointer are both acceptable. It must never exceed M*N-1.

## Timing
- Reset values: state=IDLE, s_ready=0, x_wr_en=0, mac_valid_in=0, m_valid=0, m_last=0, proto_err=0, all addresses 0.
- s_ready first rises 1 cycle after reset deasserts.
- Last input accepted in cycle t: ISSUE begins at t+1; first mac_valid_in at t+2.
- Row r: N consecutive mac_valid_in cycles, lagging the addresses by one cycle.
- mac_valid_out in cycle u: m_valid=1 from u+1 until the handshake cycle, inclusive.
- Handshake in cycle h:
  - m_valid drops at h+1.
  - Next row: ISSUE at h+1.
  - Last row: LOAD_X at h+1 (s_ready=1 at h+1).
- s_valid gaps in LOAD_X stall wr_ptr with no write.
- m_ready held high before m_valid has no effect.
- m_ready may stay low indefinitely; OUT and all addresses hold.
- Reset asserted mid-operation returns to IDLE at once. Partial rows and vectors are discarded, and m_valid drops asynchronously.

## Test plan
- Reset/startup: hold reset=0 for 3 cycles, release.
  - All outputs 0 during reset.
  - s_ready=0 in the first cycle after release, 1 in the next.
- Load and issue (M=5, N=2): send x words 3, -2 back-to-back.
  - x_wr_en at addr 0 then 1.
  - ISSUE shows (x_addr,w_addr,b_addr) = (0,0,0) then (1,1,0).
  - mac_valid_in high exactly 2 cycles, one cycle later.
- Full vector with MAC stub (mac_valid_out 3 cycles after the last mac_valid_in) and m_ready=1:
  - 5 m_valid pulses; w_addr sequence 0..9; b_addr 0..4.
  - m_last only on the 5th; s_ready returns to 1 afterward.
- Backpressure: m_ready=0 for 4 cycles on row 2.
  - m_valid held; w_addr stays 5; no mac_valid_in.
  - Row 3 issues (w_addr 6) the cycle after m_ready=1.
- Input gaps and ignored input: s_valid pattern 1,0,0,1.
  - Writes at cycles 1 and 4 only (addrs 0,1).
  - s_valid during ISSUE/OUT produces no x_wr_en.
- Error/reset: pulse mac_valid_out during LOAD_X → proto_err=1 and stays 1. Then assert reset during ISSUE of row 1 → state IDLE, proto_err=0, m_valid=0 with no clk edge needed.
